// File: rtl/slice_alarm_sched.sv
// Round-robin time-slice scheduler for 4 process slots, each with a CPU budget and an elapsed-time alarm.
// Completions are queued in PEND and reported one per cycle, lowest slot id first.
module slice_alarm_sched #(
   parameter int MSB     = 3,
   parameter int QUANTUM = 2
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start_valid,
   input  logic [1:0]     start_id,
   input  logic [MSB:0]   start_cpu,
   input  logic [MSB:0]   start_timeout,
   output logic           start_ready,
   input  logic           scheduled,
   output logic           grant_valid,
   output logic [1:0]     grant_id,
   output logic           done_valid,
   output logic [1:0]     done_id,
   output logic           done_timeout,
   output logic [MSB:0]   done_cpu,
   output logic [3:0]     busy
);

   typedef enum logic [1:0] {IDLE, ACTIVE, PEND} slotState_t;

   localparam logic [MSB:0] ONE   = (MSB+1)'(1);
   localparam logic [MSB:0] QUANT = (MSB+1)'(QUANTUM);

   slotState_t   slotState [4];
   logic [MSB:0] cpuLeft   [4];
   logic [MSB:0] alarmLeft [4];
   logic [MSB:0] used      [4];
   logic [3:0]   timedOut;
   logic [MSB:0] quantCnt;

   logic         charge;
   logic [3:0]   exhaust, expire, retire, eligible;
   logic [MSB:0] quantNext;
   logic         reselect;
   logic         nextFound;
   logic [1:0]   nextId;
   logic [1:0]   probeId;
   logic         emitFound;
   logic [1:0]   emitId;

   assign start_ready = (slotState[start_id] == IDLE);

   always_comb begin
      busy = '0;
      for (int i = 0; i < 4; i++) busy[i] = (slotState[i] != IDLE);
   end

   always_comb begin
      charge    = grant_valid && scheduled;
      exhaust   = '0;
      expire    = '0;
      retire    = '0;
      eligible  = '0;
      for (int i = 0; i < 4; i++) begin
         exhaust[i]  = charge && (grant_id == 2'(i)) && (cpuLeft[i] == ONE);
         expire[i]   = (slotState[i] == ACTIVE) && (alarmLeft[i] == ONE);
         retire[i]   = exhaust[i] || expire[i];
         // Slots started at this edge are still IDLE here, so they wait one edge before arbitration.
         eligible[i] = (slotState[i] == ACTIVE) && !retire[i];
      end

      quantNext = (charge && quantCnt < QUANT) ? quantCnt + ONE : quantCnt;
      reselect  = !grant_valid || retire[grant_id] || (quantNext == QUANT);

      nextFound = 1'b0;
      nextId    = grant_id;
      probeId   = grant_id;
      for (int k = 1; k <= 4; k++) begin
         probeId = grant_id + 2'(k);
         if (!nextFound && eligible[probeId]) begin
            nextFound = 1'b1;
            nextId    = probeId;
         end
      end

      // The slot whose pulse is on the wire this cycle leaves PEND at this edge.
      emitFound = 1'b0;
      emitId    = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (slotState[i] == PEND && !(done_valid && done_id == 2'(i))) begin
            emitFound = 1'b1;
            emitId    = 2'(i);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            slotState[i] <= IDLE;
            cpuLeft[i]   <= '0;
            alarmLeft[i] <= '0;
            used[i]      <= '0;
         end
         timedOut     <= '0;
         quantCnt     <= '0;
         grant_valid  <= 1'b0;
         grant_id     <= 2'd0;
         done_valid   <= 1'b0;
         done_id      <= 2'd0;
         done_timeout <= 1'b0;
         done_cpu     <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            case (slotState[i])
               IDLE: begin
                  if (start_valid && start_id == 2'(i)) begin
                     cpuLeft[i]   <= start_cpu;
                     alarmLeft[i] <= start_timeout;
                     used[i]      <= '0;
                     timedOut[i]  <= 1'b0;
                     slotState[i] <= (start_cpu == '0) ? PEND : ACTIVE;
                  end
               end
               ACTIVE: begin
                  if (charge && grant_id == 2'(i) && cpuLeft[i] != '0) begin
                     cpuLeft[i] <= cpuLeft[i] - ONE;
                     used[i]    <= used[i] + ONE;
                  end
                  if (alarmLeft[i] != '0) alarmLeft[i] <= alarmLeft[i] - ONE;
                  if (retire[i]) begin
                     slotState[i] <= PEND;
                     timedOut[i]  <= !exhaust[i];
                  end
               end
               PEND: begin
                  if (done_valid && done_id == 2'(i)) slotState[i] <= IDLE;
               end
               default: slotState[i] <= IDLE;
            endcase
         end

         if (reselect) begin
            grant_valid <= nextFound;
            if (nextFound) grant_id <= nextId;
            quantCnt <= '0;
         end else begin
            quantCnt <= quantNext;
         end

         done_valid <= emitFound;
         if (emitFound) begin
            done_id      <= emitId;
            done_timeout <= timedOut[emitId];
            done_cpu     <= used[emitId];
         end
      end
   end

endmodule

// File: tb/tb_slice_alarm_sched.sv
// Directed bench for slice_alarm_sched: a round-robin vector table plus hand-written corner sequences.
module tb_slice_alarm_sched;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       start_valid;
   logic [1:0] start_id;
   logic [3:0] start_cpu;
   logic [3:0] start_timeout;
   logic       start_ready;
   logic       scheduled;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic       done_valid;
   logic [1:0] done_id;
   logic       done_timeout;
   logic [3:0] done_cpu;
   logic [3:0] busy;

   int testsRun = 0;
   int testsFailed = 0;

   slice_alarm_sched #(.MSB(3), .QUANTUM(2)) dut (
      .clock(clock), .reset_n(reset_n),
      .start_valid(start_valid), .start_id(start_id), .start_cpu(start_cpu),
      .start_timeout(start_timeout), .start_ready(start_ready),
      .scheduled(scheduled),
      .grant_valid(grant_valid), .grant_id(grant_id),
      .done_valid(done_valid), .done_id(done_id), .done_timeout(done_timeout),
      .done_cpu(done_cpu), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       sv;
      logic [1:0] sid;
      logic [3:0] scpu;
      logic [3:0] sto;
      logic       sched;
      logic       gv;
      logic [1:0] gid;
      logic       dv;
      logic [1:0] did;
      logic       dto;
      logic [3:0] dcpu;
      logic [3:0] bsy;
   } vec_t;

   vec_t rr [16];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic startSlot(input logic [1:0] id, input logic [3:0] cpu, input logic [3:0] to);
      start_valid   = 1'b1;
      start_id      = id;
      start_cpu     = cpu;
      start_timeout = to;
      tick();
      start_valid   = 1'b0;
   endtask

   // Ticks until a done pulse; reports latency in edges and how many sampled cycles showed a grant.
   task automatic waitDone(input int budget, output int lat, output int grants, output bit got);
      lat = 0;
      grants = 0;
      got = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         tick();
         if (done_valid) begin
            got = 1'b1;
            lat = c;
            break;
         end
         if (grant_valid) grants++;
      end
   endtask

   initial begin
      int  lat, grants, pulses;
      bit  got;

      // Round robin, ids 0..2 with cpu=4, QUANTUM=2, scheduled=1; one row per edge.
      //          sv sid cpu to sch | gv gid dv did dto dcpu busy
      rr[0]  = '{1, 0, 4, 0, 1,   0, 0, 0, 0, 0, 0, 4'b0001};
      rr[1]  = '{1, 1, 4, 0, 1,   1, 0, 0, 0, 0, 0, 4'b0011};
      rr[2]  = '{1, 2, 4, 0, 1,   1, 0, 0, 0, 0, 0, 4'b0111};
      rr[3]  = '{0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 4'b0111};
      rr[4]  = '{0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 4'b0111};
      rr[5]  = '{0, 0, 0, 0, 1,   1, 2, 0, 0, 0, 0, 4'b0111};
      rr[6]  = '{0, 0, 0, 0, 1,   1, 2, 0, 0, 0, 0, 4'b0111};
      rr[7]  = '{0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 4'b0111};
      rr[8]  = '{0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 4'b0111};
      rr[9]  = '{0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 4'b0111};
      rr[10] = '{0, 0, 0, 0, 1,   1, 1, 1, 0, 0, 4, 4'b0111};
      rr[11] = '{0, 0, 0, 0, 1,   1, 2, 0, 0, 0, 0, 4'b0110};
      rr[12] = '{0, 0, 0, 0, 1,   1, 2, 1, 1, 0, 4, 4'b0110};
      rr[13] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 4'b0100};
      rr[14] = '{0, 0, 0, 0, 1,   0, 0, 1, 2, 0, 4, 4'b0100};
      rr[15] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 4'b0000};

      reset_n = 1'b0;
      start_valid = 1'b0;
      start_id = 2'd0;
      start_cpu = 4'd0;
      start_timeout = 4'd0;
      scheduled = 1'b0;
      tick();
      tick();
      check("reset grant_valid", 16'(grant_valid), 16'd0);
      check("reset grant_id", 16'(grant_id), 16'd0);
      check("reset done_valid", 16'(done_valid), 16'd0);
      check("reset done_id", 16'(done_id), 16'd0);
      check("reset done_timeout", 16'(done_timeout), 16'd0);
      check("reset done_cpu", 16'(done_cpu), 16'd0);
      check("reset busy", 16'(busy), 16'd0);
      reset_n = 1'b1;

      for (int r = 0; r < 16; r++) begin
         start_valid   = rr[r].sv;
         start_id      = rr[r].sid;
         start_cpu     = rr[r].scpu;
         start_timeout = rr[r].sto;
         scheduled     = rr[r].sched;
         tick();
         check($sformatf("rr[%0d] grant_valid", r), 16'(grant_valid), 16'(rr[r].gv));
         if (rr[r].gv) check($sformatf("rr[%0d] grant_id", r), 16'(grant_id), 16'(rr[r].gid));
         check($sformatf("rr[%0d] done_valid", r), 16'(done_valid), 16'(rr[r].dv));
         if (rr[r].dv) begin
            check($sformatf("rr[%0d] done_id", r), 16'(done_id), 16'(rr[r].did));
            check($sformatf("rr[%0d] done_timeout", r), 16'(done_timeout), 16'(rr[r].dto));
            check($sformatf("rr[%0d] done_cpu", r), 16'(done_cpu), 16'(rr[r].dcpu));
         end
         check($sformatf("rr[%0d] busy", r), 16'(busy), 16'(rr[r].bsy));
      end
      start_valid = 1'b0;

      // Single slot: three charged grant cycles, then a budget completion.
      scheduled = 1'b1;
      startSlot(2'd0, 4'd3, 4'd0);
      waitDone(20, lat, grants, got);
      check("single got done", 16'(got), 16'd1);
      check("single grant cycles", 16'(grants), 16'd3);
      check("single done_id", 16'(done_id), 16'd0);
      check("single done_timeout", 16'(done_timeout), 16'd0);
      check("single done_cpu", 16'(done_cpu), 16'd3);
      tick();
      check("single busy after", 16'(busy), 16'd0);

      // Budget exhaustion and alarm expiry on the same edge: budget wins.
      startSlot(2'd0, 4'd2, 4'd3);
      waitDone(20, lat, grants, got);
      check("tie got done", 16'(got), 16'd1);
      check("tie done_timeout", 16'(done_timeout), 16'd0);
      check("tie done_cpu", 16'(done_cpu), 16'd2);
      tick();

      // Alarm with the CPU stalled: retires 3 edges after accept, pulse on the next.
      scheduled = 1'b0;
      startSlot(2'd1, 4'd5, 4'd3);
      waitDone(20, lat, grants, got);
      check("alarm got done", 16'(got), 16'd1);
      check("alarm latency", 16'(lat), 16'd4);
      check("alarm done_id", 16'(done_id), 16'd1);
      check("alarm done_timeout", 16'(done_timeout), 16'd1);
      check("alarm done_cpu", 16'(done_cpu), 16'd0);
      tick();
      check("alarm busy after", 16'(busy), 16'd0);

      // Slots 3 and 2 expire on the same edge; a start into busy slot 2 is ignored.
      startSlot(2'd3, 4'd9, 4'd3);
      startSlot(2'd2, 4'd9, 4'd2);
      start_id = 2'd2;
      #1;
      check("busy slot start_ready", 16'(start_ready), 16'd0);
      startSlot(2'd2, 4'd1, 4'd0);
      tick();
      check("simul busy", 16'(busy), 16'b1100);
      tick();
      check("simul first done_valid", 16'(done_valid), 16'd1);
      check("simul first done_id", 16'(done_id), 16'd2);
      check("simul first done_timeout", 16'(done_timeout), 16'd1);
      check("simul first done_cpu", 16'(done_cpu), 16'd0);
      start_id = 2'd2;
      #1;
      check("leaving PEND start_ready", 16'(start_ready), 16'd0);
      tick();
      check("simul second done_valid", 16'(done_valid), 16'd1);
      check("simul second done_id", 16'(done_id), 16'd3);
      check("simul second done_timeout", 16'(done_timeout), 16'd1);
      check("slot2 idle start_ready", 16'(start_ready), 16'd1);
      tick();
      check("simul no extra done", 16'(done_valid), 16'd0);
      check("simul busy after", 16'(busy), 16'd0);

      // cpu=0 start completes without ever being granted.
      scheduled = 1'b1;
      startSlot(2'd1, 4'd0, 4'd0);
      check("cpu0 grant at accept", 16'(grant_valid), 16'd0);
      waitDone(10, lat, grants, got);
      check("cpu0 got done", 16'(got), 16'd1);
      check("cpu0 grant cycles", 16'(grants), 16'd0);
      check("cpu0 grant at done", 16'(grant_valid), 16'd0);
      check("cpu0 done_id", 16'(done_id), 16'd1);
      check("cpu0 done_timeout", 16'(done_timeout), 16'd0);
      check("cpu0 done_cpu", 16'(done_cpu), 16'd0);
      tick();

      // Reset while two slots are active discards them silently.
      startSlot(2'd0, 4'd9, 4'd0);
      startSlot(2'd1, 4'd9, 4'd0);
      tick();
      check("prereset grant_valid", 16'(grant_valid), 16'd1);
      check("prereset busy", 16'(busy), 16'b0011);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("midreset busy", 16'(busy), 16'd0);
      check("midreset grant_valid", 16'(grant_valid), 16'd0);
      check("midreset done_valid", 16'(done_valid), 16'd0);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (done_valid || grant_valid) pulses++;
      end
      check("postreset quiet", 16'(pulses), 16'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
